// File: rtl/approx_loa_adder_pipe.sv
// Two-stage lower-part-OR approximate adder with valid/ready flow control.
// Define APPROX_LOA_ERR_MON_EN to build the exact-sum error path and the error monitor.
module approx_loa_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4,
    parameter int ET          = 5,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    input  logic             stats_clr,
    output logic [WIDTH:0]   err_max,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             err_flag
);

    localparam int K = APPROX_BITS;

    // Bit loop keeps K = 0 and K = WIDTH legal without zero-width slices.
    function automatic logic [WIDTH:0] loa_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] lo;
        logic [WIDTH:0] carry;
        logic [WIDTH:0] hi;
        lo    = '0;
        carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < K)
                lo[i] = a[i] | b[i];
            if (i == K - 1)
                carry[0] = a[i] & b[i];
        end
        hi = ({1'b0, a} >> K) + ({1'b0, b} >> K) + carry;
        return lo | (hi << K);
    endfunction

    logic             adv1, adv2;
    logic             vld_p1_d, vld_p1_q;
    logic [WIDTH-1:0] a_p1_d, a_p1_q;
    logic [WIDTH-1:0] b_p1_d, b_p1_q;
    logic [WIDTH:0]   sum_p1;
    logic             vld_p2_d, vld_p2_q;
    logic [WIDTH:0]   sum_p2_d, sum_p2_q;

    always_comb begin
        adv2     = ~vld_p2_q | out_ready;
        adv1     = ~vld_p1_q | adv2;
        vld_p1_d = adv1 ? in_valid : vld_p1_q;
        a_p1_d   = a_p1_q;
        b_p1_d   = b_p1_q;
        if (adv1 && in_valid) begin
            a_p1_d = in_a;
            b_p1_d = in_b;
        end
        // S1 -> S2 boundary
        sum_p1   = loa_sum(a_p1_q, b_p1_q);
        vld_p2_d = adv2 ? vld_p1_q : vld_p2_q;
        sum_p2_d = (adv2 && vld_p1_q) ? sum_p1 : sum_p2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            sum_p2_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            sum_p2_q <= sum_p2_d;
        end
    end

    // Operand registers carry no state worth clearing; validity is tracked by vld_p1_q.
    always_ff @(posedge clk) begin
        a_p1_q <= a_p1_d;
        b_p1_q <= b_p1_d;
    end

    assign in_ready  = adv1;
    assign out_valid = vld_p2_q;
    assign out_sum   = sum_p2_q;

`ifdef APPROX_LOA_ERR_MON_EN
    localparam logic [WIDTH:0] ET_W = ET[WIDTH:0];

    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x,
                                                input logic [WIDTH:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [WIDTH:0]   exact_p1, err_p1;
    logic [WIDTH:0]   err_p2_d, err_p2_q;
    logic [WIDTH:0]   err_max_d, err_max_q;
    logic [CNT_W-1:0] viol_cnt_d, viol_cnt_q;
    logic             err_flag_d, err_flag_q;
    logic             out_xfer;

    always_comb begin
        exact_p1   = {1'b0, a_p1_q} + {1'b0, b_p1_q};
        err_p1     = abs_diff(exact_p1, sum_p1);
        err_p2_d   = (adv2 && vld_p1_q) ? err_p1 : err_p2_q;
        out_xfer   = vld_p2_q & out_ready;
        err_max_d  = err_max_q;
        viol_cnt_d = viol_cnt_q;
        err_flag_d = err_flag_q;
        // Clear takes priority so a coincident transfer is dropped from the statistics.
        if (stats_clr) begin
            err_max_d  = '0;
            viol_cnt_d = '0;
            err_flag_d = 1'b0;
        end else if (out_xfer) begin
            if (err_p2_q > err_max_q)
                err_max_d = err_p2_q;
            if (err_p2_q > ET_W) begin
                viol_cnt_d = sat_inc(viol_cnt_q);
                err_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_p2_q   <= '0;
            err_max_q  <= '0;
            viol_cnt_q <= '0;
            err_flag_q <= 1'b0;
        end else begin
            err_p2_q   <= err_p2_d;
            err_max_q  <= err_max_d;
            viol_cnt_q <= viol_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign out_err  = err_p2_q;
    assign err_max  = err_max_q;
    assign viol_cnt = viol_cnt_q;
    assign err_flag = err_flag_q;
`else
    logic unused_mon;
    assign unused_mon = stats_clr | (ET < 0);
    assign out_err    = '0;
    assign err_max    = '0;
    assign viol_cnt   = '0;
    assign err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_approx_loa_adder_pipe.sv
// Directed-vector bench for approx_loa_adder_pipe: main (K=4), saturation (CNT_W=2)
// and exact (K=0) instances share one stimulus stream.
module tb_approx_loa_adder_pipe;

`ifdef APPROX_LOA_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, stats_clr;
    logic [7:0] in_a, in_b;

    logic       m_in_ready, m_out_valid, m_flag;
    logic [8:0] m_out_sum, m_out_err, m_err_max;
    logic [7:0] m_viol;
    logic       s_in_ready, s_out_valid, s_flag;
    logic [8:0] s_out_sum, s_out_err, s_err_max;
    logic [1:0] s_viol;
    logic       x_in_ready, x_out_valid, x_flag;
    logic [8:0] x_out_sum, x_out_err, x_err_max;
    logic [7:0] x_viol;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    approx_loa_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .ET(5), .CNT_W(8)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_sum(m_out_sum), .out_err(m_out_err), .stats_clr(stats_clr),
        .err_max(m_err_max), .viol_cnt(m_viol), .err_flag(m_flag)
    );

    approx_loa_adder_pipe #(.WIDTH(8), .APPROX_BITS(4), .ET(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_err(s_out_err), .stats_clr(stats_clr),
        .err_max(s_err_max), .viol_cnt(s_viol), .err_flag(s_flag)
    );

    approx_loa_adder_pipe #(.WIDTH(8), .APPROX_BITS(0), .ET(5), .CNT_W(8)) u_exact (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(x_out_valid), .out_ready(out_ready),
        .out_sum(x_out_sum), .out_err(x_out_err), .stats_clr(stats_clr),
        .err_max(x_err_max), .viol_cnt(x_viol), .err_flag(x_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mexp(input logic [31:0] v);
        return MON ? v : 32'd0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [8:0] es, input logic [8:0] ee, input logic [8:0] ex);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({tag, "_lat"}, m_out_valid, 0);
        cyc();
        chk({tag, "_vld"}, m_out_valid, 1);
        chk({tag, "_sum"}, m_out_sum, es);
        chk({tag, "_err"}, m_out_err, mexp(ee));
        chk({tag, "_xvld"}, x_out_valid, 1);
        chk({tag, "_xsum"}, x_out_sum, ex);
        chk({tag, "_xerr"}, x_out_err, 0);
    endtask

    logic [7:0] bp_a[4]   = '{8'h12, 8'h0A, 8'h33, 8'hF0};
    logic [7:0] bp_b[4]   = '{8'h34, 8'h05, 8'h44, 8'h0F};
    logic [8:0] bp_exp[4] = '{9'h046, 9'h00F, 9'h077, 9'h0FF};

    initial begin
        int  idx;
        int  ridx;
        int  seen;
        bit  acc;

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h0F;
        in_b      = 8'h01;
        out_ready = 1'b1;
        stats_clr = 1'b0;
        repeat (2) cyc();
        chk("rst_out_valid", m_out_valid, 0);
        chk("rst_in_ready", m_in_ready, 1);
        chk("rst_out_sum", m_out_sum, 0);
        chk("rst_out_err", m_out_err, 0);
        chk("rst_err_max", m_err_max, 0);
        chk("rst_viol_cnt", m_viol, 0);
        chk("rst_err_flag", m_flag, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cyc();

        one("d0f01", 8'h0F, 8'h01, 9'h00F, 9'd1, 9'h010);
        one("d0f0f", 8'h0F, 8'h0F, 9'h01F, 9'd1, 9'h01E);
        one("dff01", 8'hFF, 8'h01, 9'h0FF, 9'd1, 9'h100);
        one("d0707", 8'h07, 8'h07, 9'h007, 9'd7, 9'h00E);
        cyc();
        chk("mon_viol_cnt", m_viol, mexp(1));
        chk("mon_err_flag", m_flag, mexp(1));
        chk("mon_err_max", m_err_max, mexp(7));
        chk("mon_sat_viol", s_viol, mexp(1));
        chk("mon_exact_max", x_err_max, 0);
        chk("mon_exact_viol", x_viol, 0);

        idx  = 0;
        ridx = 0;
        for (int c = 0; c < 20 && ridx < 4; c++) begin
            out_ready = (c >= 4);
            in_valid  = (idx < 4);
            if (idx < 4) begin
                in_a = bp_a[idx];
                in_b = bp_b[idx];
            end
            #1;
            if (c == 2) begin
                chk("bp_ready_low", m_in_ready, 0);
                chk("bp_accepted", idx, 2);
            end
            if (m_out_valid) begin
                chk("bp_sum", m_out_sum, bp_exp[ridx]);
                chk("bp_xsum", x_out_sum, bp_exp[ridx]);
                if (out_ready)
                    ridx++;
            end
            acc = in_valid & m_in_ready;
            @(posedge clk);
            #1;
            if (acc)
                idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", ridx, 4);
        repeat (3) begin
            cyc();
            chk("bp_nodup", m_out_valid, 0);
        end

        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("clr_viol", m_viol, 0);
        chk("clr_flag", m_flag, 0);
        chk("clr_max", m_err_max, 0);
        in_a = 8'h07;
        in_b = 8'h07;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        chk("sat_viol", s_viol, mexp(3));
        chk("sat_flag", s_flag, mexp(1));
        chk("sat_main_viol", m_viol, mexp(5));
        chk("sat_main_max", m_err_max, mexp(7));

        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("clrx_vld", m_out_valid, 1);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("clrx_viol", m_viol, 0);
        chk("clrx_flag", m_flag, 0);
        chk("clrx_max", m_err_max, 0);
        chk("clrx_sat_viol", s_viol, 0);
        chk("clrx_drained", m_out_valid, 0);

        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (2) cyc();
        chk("pre_rst_viol", m_viol, mexp(1));
        out_ready = 1'b0;
        in_a      = 8'h12;
        in_b      = 8'h34;
        in_valid  = 1'b1;
        cyc();
        in_a = 8'h0A;
        in_b = 8'h05;
        cyc();
        in_valid = 1'b0;
        chk("mrst_full_ready", m_in_ready, 0);
        chk("mrst_full_vld", m_out_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_out_valid", m_out_valid, 0);
        chk("mrst_in_ready", m_in_ready, 1);
        chk("mrst_out_sum", m_out_sum, 0);
        chk("mrst_viol", m_viol, 0);
        chk("mrst_flag", m_flag, 0);
        chk("mrst_max", m_err_max, 0);
        out_ready = 1'b1;
        seen      = 0;
        repeat (4) begin
            cyc();
            if (m_out_valid)
                seen++;
        end
        chk("mrst_discard", seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
